// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU bus blocks: default widths, loader states and
// bit positions of the control strobes within the control word.
package cpu_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PROG_HI = 2'd1,
    PROG_LO = 2'd2,
    DONE    = 2'd3
  } load_state_t;

  localparam int CTRL_LM = 0;
  localparam int CTRL_CE = 1;
  localparam int CTRL_WE = 2;
  localparam int CTRL_W  = 3;

endpackage

// File: rtl/nibble_loader.sv
// Nibble-serial RAM loader: pairs high/low nibbles into words and issues one
// RAM write per completed word, walking addresses 0 .. 2**ADDR_W-1.
module nibble_loader
  import cpu_pkg::*;
#(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int DATA_W = cpu_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_mode,
  input  logic [DATA_W/2-1:0] prog_nibble,
  input  logic              prog_valid,
  output logic              prog_ready,
  output logic [ADDR_W-1:0] prog_addr,
  output logic              prog_done,
  output logic              idle,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  localparam int NIB_W = DATA_W / 2;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  load_state_t       state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [NIB_W-1:0]  hi_reg, hi_next;
  logic              transfer;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      hi_reg    <= '0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      hi_reg    <= hi_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    hi_next    = hi_reg;
    prog_ready = 1'b0;
    prog_done  = 1'b0;
    wr_en      = 1'b0;
    transfer   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (prog_mode) begin
          state_next = PROG_HI;
          addr_next  = '0;
        end
      end
      PROG_HI, PROG_LO: begin
        // No handshake in the abort cycle, so a dropping prog_mode never writes.
        prog_ready = prog_mode;
        transfer   = prog_valid & prog_mode;
        if (!prog_mode) begin
          state_next = IDLE;
          hi_next    = '0;
        end else if (transfer && state_reg == PROG_HI) begin
          hi_next    = prog_nibble;
          state_next = PROG_LO;
        end else if (transfer) begin
          wr_en = 1'b1;
          if (addr_reg == LAST_ADDR) begin
            addr_next  = '0;
            state_next = DONE;
          end else begin
            addr_next  = addr_reg + 1'b1;
            state_next = PROG_HI;
          end
        end
      end
      DONE: begin
        prog_done = 1'b1;
        if (!prog_mode) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign idle      = (state_reg == IDLE);
  assign prog_addr = addr_reg;
  assign wr_addr   = addr_reg;
  assign wr_data   = {hi_reg, prog_nibble};

endmodule

// File: rtl/memory_block.sv
// RAM plus memory address register on the CPU bus; the loader takes over the
// RAM write port whenever it is not idle.
module memory_block
  import cpu_pkg::*;
#(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int DATA_W = cpu_pkg::DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   bus_in,
  output logic [DATA_W-1:0]   bus_out,
  output logic                bus_oe,
  input  logic                lm,
  input  logic                ce,
  input  logic                we,
  input  logic                prog_mode,
  input  logic [DATA_W/2-1:0] prog_nibble,
  input  logic                prog_valid,
  output logic                prog_ready,
  output logic [ADDR_W-1:0]   prog_addr,
  output logic                prog_done,
  output logic [ADDR_W-1:0]   mar_out
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] mar_reg;
  logic [CTRL_W-1:0] ctrl;
  logic              loader_idle;
  logic              cpu_active;
  logic              ld_wr_en;
  logic [ADDR_W-1:0] ld_wr_addr;
  logic [DATA_W-1:0] ld_wr_data;

  assign ctrl[CTRL_LM] = lm;
  assign ctrl[CTRL_CE] = ce;
  assign ctrl[CTRL_WE] = we;

  nibble_loader #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_loader (
    .clk        (clk),
    .rst        (rst),
    .prog_mode  (prog_mode),
    .prog_nibble(prog_nibble),
    .prog_valid (prog_valid),
    .prog_ready (prog_ready),
    .prog_addr  (prog_addr),
    .prog_done  (prog_done),
    .idle       (loader_idle),
    .wr_en      (ld_wr_en),
    .wr_addr    (ld_wr_addr),
    .wr_data    (ld_wr_data)
  );

  assign cpu_active = loader_idle & ~prog_mode;

  // Whole-array clear on reset, so the RAM is built from registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      mar_reg <= '0;
    end else if (ld_wr_en) begin
      mem[ld_wr_addr] <= ld_wr_data;
    end else if (cpu_active) begin
      if (ctrl[CTRL_WE]) begin
        mem[mar_reg] <= bus_in;
      end
      if (ctrl[CTRL_LM]) begin
        mar_reg <= bus_in[ADDR_W-1:0];
      end
    end
  end

  assign bus_oe  = cpu_active & ctrl[CTRL_CE] & ~rst;
  assign bus_out = bus_oe ? mem[mar_reg] : '0;
  assign mar_out = mar_reg;

endmodule

// File: tb/tb_memory_block.sv
// Self-checking bench for memory_block: directed steps plus randomized load
// handshakes and CPU traffic, compared against a word/nibble-count model.
module tb_memory_block;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] bus_in;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic       lm, ce, we;
  logic       prog_mode;
  logic [3:0] prog_nibble;
  logic       prog_valid;
  logic       prog_ready;
  logic [3:0] prog_addr;
  logic       prog_done;
  logic [3:0] mar_out;

  always #5 clk = ~clk;

  memory_block dut (
    .clk        (clk),
    .rst        (rst),
    .bus_in     (bus_in),
    .bus_out    (bus_out),
    .bus_oe     (bus_oe),
    .lm         (lm),
    .ce         (ce),
    .we         (we),
    .prog_mode  (prog_mode),
    .prog_nibble(prog_nibble),
    .prog_valid (prog_valid),
    .prog_ready (prog_ready),
    .prog_addr  (prog_addr),
    .prog_done  (prog_done),
    .mar_out    (mar_out)
  );

  int checks = 0;
  int errors = 0;

  // Model: RAM contents, MAR, and loader progress as a count of accepted nibbles.
  logic [7:0] m_mem [16];
  logic [3:0] m_mar;
  bit         m_loading;
  int         m_count;
  logic [3:0] m_hi;
  bit         last_accept;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    lm = 0; ce = 0; we = 0; bus_in = 8'h00;
    prog_valid = 0; prog_nibble = 4'h0;
  endtask

  task automatic cycle();
    bit         oe_e;
    bit         rdy;
    logic [7:0] out_e;
    #1;
    rdy = m_loading && (m_count < 32) && prog_mode;
    if (!rst) begin
      oe_e  = !m_loading && !prog_mode && ce;
      out_e = oe_e ? m_mem[m_mar] : 8'h00;
      chk("bus_oe", 32'(bus_oe), 32'(oe_e));
      chk("bus_out", 32'(bus_out), 32'(out_e));
      chk("prog_ready", 32'(prog_ready), 32'(rdy));
      chk("prog_done", 32'(prog_done), 32'(m_loading && m_count == 32));
      chk("mar_out", 32'(mar_out), 32'(m_mar));
      if (m_loading) chk("prog_addr", 32'(prog_addr), 32'((m_count / 2) % 16));
    end
    last_accept = 0;
    if (rst) begin
      for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
      m_mar = 4'h0; m_loading = 0; m_count = 0; m_hi = 4'h0;
    end else if (!m_loading) begin
      if (prog_mode) begin
        m_loading = 1; m_count = 0;
      end else begin
        if (we) m_mem[m_mar] = bus_in;
        if (lm) m_mar = bus_in[3:0];
      end
    end else if (!prog_mode) begin
      m_loading = 0;
    end else if (rdy && prog_valid) begin
      last_accept = 1;
      if (m_count % 2 == 0) m_hi = prog_nibble;
      else m_mem[m_count / 2] = {m_hi, prog_nibble};
      m_count++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic read_word(input logic [3:0] a, output logic [7:0] d);
    idle_inputs();
    lm = 1; bus_in = {4'h0, a};
    cycle();
    idle_inputs();
    ce = 1;
    #1 d = bus_out;
    cycle();
    ce = 0;
  endtask

  task automatic feed(input logic [3:0] nib);
    prog_valid = 1; prog_nibble = nib;
    cycle();
    prog_valid = 0;
  endtask

  logic [7:0] rd;
  logic [7:0] saved2;
  logic [3:0] mar_before;
  int         fed;
  int         guard;
  logic [3:0] nibs [32];

  initial begin
    for (int i = 0; i < 16; i++) m_mem[i] = 8'hxx;
    m_mar = 4'hx; m_loading = 0; m_count = 0; m_hi = 4'h0;
    idle_inputs();
    prog_mode = 0;
    rst = 1;
    @(negedge clk);
    cycle();
    cycle();
    rst = 0;

    // Reset state and read of a cleared word.
    #1;
    chk("rst_prog_done", 32'(prog_done), 32'd0);
    chk("rst_prog_ready", 32'(prog_ready), 32'd0);
    chk("rst_bus_oe", 32'(bus_oe), 32'd0);
    chk("rst_bus_out", 32'(bus_out), 32'd0);
    read_word(4'h5, rd);
    chk("rst_word5", 32'(rd), 32'h00);

    // Full load with random stalls; word i = {i, ~i}.
    for (int i = 0; i < 16; i++) begin
      nibs[2*i]   = 4'(i);
      nibs[2*i+1] = ~4'(i);
    end
    prog_mode = 1;
    cycle();
    fed = 0; guard = 0;
    while (fed < 32 && guard < 2000) begin
      prog_valid  = 1'($urandom_range(0, 1));
      prog_nibble = nibs[fed];
      cycle();
      if (last_accept) fed++;
      guard++;
    end
    prog_valid = 0;
    chk("load_timeout", 32'(fed), 32'd32);
    #1 chk("load_done", 32'(prog_done), 32'd1);
    for (int i = 0; i < 3; i++) feed(4'hF);
    chk("done_no_ready", 32'(prog_ready), 32'd0);
    prog_mode = 0;
    cycle();
    idle_inputs();
    lm = 1; bus_in = 8'h03;
    cycle();
    idle_inputs();
    ce = 1;
    #1;
    chk("word3_value", 32'(bus_out), 32'h3C);
    chk("word3_oe", 32'(bus_oe), 32'd1);
    cycle();
    idle_inputs();

    // Random CPU traffic, including upper bus bits on lm.
    for (int i = 0; i < 40; i++) begin
      lm = 1'($urandom_range(0, 1));
      ce = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      bus_in = 8'($urandom);
      cycle();
    end
    idle_inputs();

    // lm, we and ce in one cycle.
    lm = 1; bus_in = 8'h04; cycle();
    idle_inputs(); we = 1; bus_in = 8'h11; cycle();
    idle_inputs();
    lm = 1; we = 1; ce = 1; bus_in = 8'h99;
    #1 chk("simul_old_word", 32'(bus_out), 32'h11);
    cycle();
    idle_inputs();
    #1 chk("simul_mar", 32'(mar_out), 32'd9);
    read_word(4'h4, rd);
    chk("simul_new_word", 32'(rd), 32'h99);

    // CPU strobes ignored while loading.
    saved2 = m_mem[2];
    mar_before = mar_out;
    prog_mode = 1;
    ce = 1; lm = 1; bus_in = 8'h07;
    #1 chk("guard_oe", 32'(bus_oe), 32'd0);
    cycle();
    cycle();
    chk("guard_mar", 32'(mar_out), 32'(mar_before));
    idle_inputs();

    // Abort after the high nibble of word 2.
    feed(4'h5); feed(4'hA); feed(4'hC); feed(4'h3); feed(4'hA);
    prog_mode = 0;
    cycle();
    #1;
    chk("abort_ready", 32'(prog_ready), 32'd0);
    chk("abort_done", 32'(prog_done), 32'd0);
    read_word(4'h0, rd); chk("abort_word0", 32'(rd), 32'h5A);
    read_word(4'h1, rd); chk("abort_word1", 32'(rd), 32'hC3);
    read_word(4'h2, rd); chk("abort_word2", 32'(rd), 32'(saved2));
    prog_mode = 1;
    cycle();
    #1 chk("reentry_addr", 32'(prog_addr), 32'd0);

    // Reset in the middle of a load clears the whole RAM.
    feed(4'h7); feed(4'h8); feed(4'h9);
    rst = 1;
    cycle();
    rst = 0;
    prog_mode = 0;
    cycle();
    for (int i = 0; i < 16; i++) begin
      read_word(4'(i), rd);
      chk("rst_clear", 32'(rd), 32'h00);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_block.md
Name: memory_block

Overview:
- 16x8 RAM with its memory address register (MAR): the reader/responder side of the CPU bus that the program counter and control block drive.
- CPU side: the control block latches an address from the bus (lm), places RAM data on the bus (ce), or stores bus data (we).
- Loader side: a nibble-serial programming port, fed from the ui_in pins, fills RAM before run mode.
- The top level sees the bus as separate in/out/output-enable vectors.

Parameters:
- ADDR_W, 4, address width; depth = 2**ADDR_W.
- DATA_W, 8, word width; must be even, because a load nibble is DATA_W/2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- bus_in  input  DATA_W  bus value driven by other blocks
- bus_out  output  DATA_W  RAM read data; 0 when bus_oe=0
- bus_oe  output  1  this block is driving the bus
- lm  input  1  load MAR from bus_in[ADDR_W-1:0]
- ce  input  1  output RAM[MAR] on bus
- we  input  1  write bus_in into RAM[MAR]
- prog_mode  input  1  1 = loader owns the RAM; CPU controls ignored
- prog_nibble  input  DATA_W/2  load data nibble
- prog_valid  input  1  nibble present
- prog_ready  output  1  block accepts a nibble this cycle
- prog_addr  output  ADDR_W  next load address
- prog_done  output  1  all words loaded
- mar_out  output  ADDR_W  current MAR, for debug pins

Behaviour:
- Reset (rst=1 at clk edge):
  - MAR=0, every RAM word=0.
  - State=IDLE, prog_addr=0, hi-nibble holding register=0.
  - bus_oe=0, bus_out=0, prog_ready=0, prog_done=0.
  - Reset overrides every other input in that cycle.
- CPU side (active only when state=IDLE and prog_mode=0):
  - Read is combinational: bus_oe=ce, bus_out = ce ? RAM[MAR] : 0. Data is valid in the same cycle ce is high.
  - lm=1: MAR <= bus_in[ADDR_W-1:0] at the edge.
  - we=1: RAM[MAR] <= bus_in at the edge.
  - lm and we together: the write uses the old MAR, then MAR updates.
  - ce and we together: bus_out shows the old word; the new word is visible from the next cycle.
- Loader FSM, states IDLE, PROG_HI, PROG_LO, DONE:
  - IDLE -> PROG_HI when prog_mode=1. prog_addr=0 on entry.
  - PROG_HI: prog_ready=1. On prog_valid&prog_ready, latch the nibble as the high half and go to PROG_LO.
  - PROG_LO: prog_ready=1. On a transfer, RAM[prog_addr] <= {hi, nibble}.
    - If prog_addr = 2**ADDR_W-1: go to DONE and wrap prog_addr to 0.
    - Otherwise prog_addr++ and go to PROG_HI.
  - DONE: prog_ready=0, prog_done=1. Stays here while prog_mode=1.
  - From any non-IDLE state, prog_mode=0 -> IDLE next edge.
    - A pending high nibble is discarded.
    - Words already written are kept.
    - MAR is unchanged.
  - prog_done clears on return to IDLE.
- Guards while prog_mode=1 or state!=IDLE:
  - lm, ce and we are ignored; bus_oe=0.
  - prog_ready is 0 in IDLE, so prog_valid in IDLE is dropped.
- Re-entering prog_mode restarts loading at address 0.
- Width rules:
  - Upper bus_in bits above ADDR_W are ignored by lm.
  - prog_addr and MAR wrap modulo 2**ADDR_W.

Decomposition:
- Shared package `cpu_pkg`:
  - ADDR_W and DATA_W defaults.
  - Loader state enum (IDLE/PROG_HI/PROG_LO/DONE).
  - Named indices for lm/ce/we within the control-signal word, so the top level wires them by name.
- One natural sub-module: `nibble_loader`, holding the FSM, prog_addr, the hi-nibble register and the handshake. It outputs a write strobe, address and data to the RAM core in memory_block.

Test Plan:
- Reset check: after rst, prog_done=0, prog_ready=0, bus_oe=0, bus_out=0. Then lm with bus_in=0x05 and ce gives bus_out=0x00.
- Full load: prog_mode=1 and 32 nibbles, with word i = {i, ~i} (0x0F, 0x1E, ...). Expect prog_done=1 after the 32nd transfer. Then prog_mode=0; lm bus_in=0x03, ce -> bus_out=0x3C, bus_oe=1 in the same cycle.
- Handshake stalls: prog_valid toggled randomly during load -> a write happens only on prog_valid&prog_ready. prog_addr advances once per 2 accepted nibbles. In DONE, prog_valid=1 gives prog_ready=0 and RAM is unchanged.
- Abort mid-word: high nibble 0xA accepted at address 2, then prog_mode=0. Word 2 keeps its old value, words 0-1 keep their loaded values, state=IDLE next cycle. Re-entry gives prog_addr=0.
- Simultaneous CPU ops: MAR=4 holds 0x11. One cycle of lm=1, we=1, ce=1 with bus_in=0x99 gives bus_out=0x11 that cycle. Afterwards RAM[4]=0x99 and MAR=9.
- Guard and reset: during prog_mode=1, ce=1 gives bus_oe=0, and lm with bus_in=0x07 leaves mar_out unchanged. rst mid-load returns all RAM words to 0x00.
